detector_readout_axis: RTL and testbench

- Readout end of the coincidence detector.
- When the detector signals the end of a counting window, the block snapshots the clock count, the per-channel counts and the pairwise coincidence counts.
- It then streams them as one AXI4-Stream frame to the DMA/PS side.
- It decouples the detector's next window from downstream backpressure and flags lost frames.

---
 rtl/detector_readout_axis.sv | 198 +++++++++++++++++++
 tb/tb_detector_readout_axis.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_readout_axis.sv
// Readout end of the coincidence detector.
// On an enabled end-of-window strobe it snapshots the clock count, the
// per-channel counts and the pairwise coincidence counts. It then streams
// them as one AXI4-Stream frame:
//   word 0           header {seq, NCHAN, NCOMB}
//   word 1           clock count
//   words 2..        channel counts
//   remaining words  pair counts
// Strobes that arrive while a frame is still in flight are dropped and counted.
module detector_readout_axis #(
  parameter int NCHAN = 4,
  parameter int NBITS = 32
) (
  input  logic                                  Clk,
  input  logic                                  Rst_n,
  input  logic                                  Enable_i,
  input  logic                                  Done_i,
  input  logic [NBITS-1:0]                      Cnt_Clk_i,
  input  logic [NCHAN*NBITS-1:0]                Cnt_chann_i,
  input  logic [(NCHAN*(NCHAN-1)/2)*NBITS-1:0]  Cnt_pairs_i,
  input  logic                                  Clr_ovf_i,
  output logic [NBITS-1:0]                      M_AXIS_tdata,
  output logic                                  M_AXIS_tvalid,
  input  logic                                  M_AXIS_tready,
  output logic                                  M_AXIS_tlast,
  output logic                                  Busy_o,
  output logic                                  Overrun_o,
  output logic [15:0]                           Drop_cnt_o,
  output logic [15:0]                           Seq_o
);

  localparam int NCOMB = NCHAN * (NCHAN - 1) / 2;
  localparam int L     = 2 + NCHAN + NCOMB;
  localparam int IW    = $clog2(L + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Header word: sequence number and frame geometry, zero-extended to NBITS.
  function automatic logic [NBITS-1:0] header_word(input logic [15:0] seq);
    header_word = NBITS'({seq, 8'(NCHAN), 8'(NCOMB)});
  endfunction

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [15:0]                seq_q, seq_d;
  logic [15:0]                snap_seq_q, snap_seq_d;
  logic [NBITS-1:0]           snap_clk_q, snap_clk_d;
  logic [NCHAN*NBITS-1:0]     snap_chann_q, snap_chann_d;
  logic [NCOMB*NBITS-1:0]     snap_pairs_q, snap_pairs_d;
  logic [NBITS-1:0]           tdata_q, tdata_d;
  logic                       tlast_q, tlast_d;
  logic                       ovf_q, ovf_d;
  logic [15:0]                drop_q, drop_d;

  logic                       hs_s;
  logic                       last_s;
  logic                       final_hs_s;
  logic                       done_s;
  logic                       capture_s;
  logic                       drop_s;
  logic [IW-1:0]              idx_nxt_s;
  logic [NBITS-1:0]           frame_s [L];
  logic [NBITS-1:0]           word_nxt_s;

  // Handshake, capture and drop decisions for the current cycle.
  always_comb begin
    hs_s       = (state_q == SEND) && M_AXIS_tready;
    last_s     = (idx_q == IW'(L - 1));
    final_hs_s = hs_s && last_s;
    done_s     = Done_i && Enable_i;
    capture_s  = done_s && ((state_q == IDLE) || final_hs_s);
    drop_s     = done_s && (state_q == SEND) && !final_hs_s;
    idx_nxt_s  = idx_q + IW'(1);
  end

  // Lay the held snapshot out in frame order.
  always_comb begin
    frame_s[0] = header_word(snap_seq_q);
    frame_s[1] = snap_clk_q;
    for (int i = 0; i < NCHAN; i++) begin
      frame_s[2 + i] = snap_chann_q[i*NBITS +: NBITS];
    end
    for (int p = 0; p < NCOMB; p++) begin
      frame_s[2 + NCHAN + p] = snap_pairs_q[p*NBITS +: NBITS];
    end
  end

  // Word that follows the one currently on the bus.
  always_comb begin
    word_nxt_s = '0;
    if (idx_nxt_s < IW'(L)) begin
      word_nxt_s = frame_s[idx_nxt_s];
    end else begin
      word_nxt_s = '0;
    end
  end

  // Next-state logic for the frame sequencer and its output registers.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    snap_seq_d   = snap_seq_q;
    snap_clk_d   = snap_clk_q;
    snap_chann_d = snap_chann_q;
    snap_pairs_d = snap_pairs_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    if (capture_s) begin
      // The header goes out straight from the live seq so that word 0 is on
      // the bus one cycle after the strobe, even back-to-back.
      state_d      = SEND;
      idx_d        = '0;
      seq_d        = seq_q + 16'd1;
      snap_seq_d   = seq_q;
      snap_clk_d   = Cnt_Clk_i;
      snap_chann_d = Cnt_chann_i;
      snap_pairs_d = Cnt_pairs_i;
      tdata_d      = header_word(seq_q);
      tlast_d      = 1'b0;
    end else if (hs_s) begin
      if (last_s) begin
        state_d = IDLE;
        idx_d   = '0;
        tdata_d = '0;
        tlast_d = 1'b0;
      end else begin
        idx_d   = idx_nxt_s;
        tdata_d = word_nxt_s;
        tlast_d = (idx_nxt_s == IW'(L - 1));
      end
    end else begin
      state_d = state_q;
    end
  end

  // Lost-frame bookkeeping: a drop on the same edge as a clear wins.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop_s) begin
      ovf_d = 1'b1;
      if (Clr_ovf_i) begin
        drop_d = 16'd1;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
    end else if (Clr_ovf_i) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end else begin
      ovf_d  = ovf_q;
    end
  end

  // State, snapshot and output registers; reset abandons any frame at once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      seq_q        <= 16'd0;
      snap_seq_q   <= 16'd0;
      snap_clk_q   <= '0;
      snap_chann_q <= '0;
      snap_pairs_q <= '0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      snap_seq_q   <= snap_seq_d;
      snap_clk_q   <= snap_clk_d;
      snap_chann_q <= snap_chann_d;
      snap_pairs_q <= snap_pairs_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tvalid = (state_q == SEND);
  assign M_AXIS_tlast  = tlast_q;
  assign Busy_o        = (state_q == SEND);
  assign Overrun_o     = ovf_q;
  assign Drop_cnt_o    = drop_q;
  assign Seq_o         = seq_q;

endmodule

// File: tb/tb_detector_readout_axis.sv
// Directed bench for detector_readout_axis with the default geometry
// (4 channels, 6 pairs, 12-word frames).
module tb_detector_readout_axis;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Enable_i;
  logic         Done_i;
  logic [31:0]  Cnt_Clk_i;
  logic [127:0] Cnt_chann_i;
  logic [191:0] Cnt_pairs_i;
  logic         Clr_ovf_i;
  logic [31:0]  M_AXIS_tdata;
  logic         M_AXIS_tvalid;
  logic         M_AXIS_tready;
  logic         M_AXIS_tlast;
  logic         Busy_o;
  logic         Overrun_o;
  logic [15:0]  Drop_cnt_o;
  logic [15:0]  Seq_o;

  int total  = 0;
  int passed = 0;

  detector_readout_axis #(.NCHAN(4), .NBITS(32)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Enable_i     (Enable_i),
    .Done_i       (Done_i),
    .Cnt_Clk_i    (Cnt_Clk_i),
    .Cnt_chann_i  (Cnt_chann_i),
    .Cnt_pairs_i  (Cnt_pairs_i),
    .Clr_ovf_i    (Clr_ovf_i),
    .M_AXIS_tdata (M_AXIS_tdata),
    .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready),
    .M_AXIS_tlast (M_AXIS_tlast),
    .Busy_o       (Busy_o),
    .Overrun_o    (Overrun_o),
    .Drop_cnt_o   (Drop_cnt_o),
    .Seq_o        (Seq_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Count vector: clock=ck, channel i = base+i+1, pair p = base+5+p.
  task automatic set_inputs(input logic [31:0] ck, input int base);
    Cnt_Clk_i = ck;
    for (int i = 0; i < 4; i++) Cnt_chann_i[i*32 +: 32] = 32'(base + i + 1);
    for (int p = 0; p < 6; p++) Cnt_pairs_i[p*32 +: 32] = 32'(base + 5 + p);
  endtask

  task automatic pulse_done(input logic en);
    @(negedge Clk);
    Enable_i = en;
    Done_i   = 1'b1;
    @(posedge Clk);
    #1;
    Done_i   = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge Clk);
    Clr_ovf_i = 1'b1;
    @(posedge Clk);
    #1;
    Clr_ovf_i = 1'b0;
  endtask

  // Expected word k of a frame built from set_inputs(ck, base) with header seq sq.
  function automatic logic [31:0] exp_word(input logic [15:0] sq, input logic [31:0] ck,
                                           input int base, input int k);
    if (k == 0)      exp_word = {sq, 8'd4, 8'd6};
    else if (k == 1) exp_word = ck;
    else             exp_word = 32'(base + k - 1);
  endfunction

  // Receive one frame; call right after the capturing edge. Done_i is pulsed
  // on the handshake edge of words d1/d2 (-1 for none).
  task automatic recv(input string nm, input logic [15:0] sq, input logic [31:0] ck,
                      input int base, input bit bp, input int d1, input int d2);
    int k = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [31:0] hd = 32'd0;
    logic hl = 1'b0;
    while (k < 12 && cyc < 400) begin
      @(negedge Clk);
      Done_i = 1'b0;
      cyc++;
      chk({nm, "_tvalid"}, 64'(M_AXIS_tvalid), 64'd1);
      chk({nm, "_busy"}, 64'(Busy_o), 64'd1);
      if (held) begin
        chk({nm, "_hold_data"}, 64'(M_AXIS_tdata), 64'(hd));
        chk({nm, "_hold_last"}, 64'(M_AXIS_tlast), 64'(hl));
      end
      M_AXIS_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        chk({nm, "_data"}, 64'(M_AXIS_tdata), 64'(exp_word(sq, ck, base, k)));
        chk({nm, "_last"}, 64'(M_AXIS_tlast), 64'(k == 11));
        if (k == d1 || k == d2) Done_i = 1'b1;
        k++;
        held = 1'b0;
      end else if (M_AXIS_tvalid) begin
        held = 1'b1;
        hd   = M_AXIS_tdata;
        hl   = M_AXIS_tlast;
      end else begin
        held = 1'b0;
      end
    end
    chk({nm, "_words"}, 64'(k), 64'd12);
    if (!bp) chk({nm, "_cycles"}, 64'(cyc), 64'd12);
  endtask

  task automatic idle_check(input string nm);
    @(negedge Clk);
    Done_i = 1'b0;
    chk({nm, "_idle_tvalid"}, 64'(M_AXIS_tvalid), 64'd0);
    chk({nm, "_idle_busy"}, 64'(Busy_o), 64'd0);
  endtask

  initial begin
    Rst_n = 1'b0;
    Enable_i = 1'b1;
    Done_i = 1'b0;
    Clr_ovf_i = 1'b0;
    M_AXIS_tready = 1'b1;
    set_inputs(32'd0, 0);
    #12;
    chk("rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("rst_tdata", 64'(M_AXIS_tdata), 64'd0);
    chk("rst_tlast", 64'(M_AXIS_tlast), 64'd0);
    chk("rst_busy", 64'(Busy_o), 64'd0);
    chk("rst_ovf", 64'(Overrun_o), 64'd0);
    chk("rst_drop", 64'(Drop_cnt_o), 64'd0);
    chk("rst_seq", 64'(Seq_o), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Single frame at full throughput.
    set_inputs(32'd50, 0);
    pulse_done(1'b1);
    recv("single", 16'd0, 32'd50, 0, 1'b0, -1, -1);
    idle_check("single");
    chk("single_seq", 64'(Seq_o), 64'd1);

    // Same frame under random backpressure.
    pulse_done(1'b1);
    recv("bp", 16'd1, 32'd50, 0, 1'b1, -1, -1);
    idle_check("bp");
    chk("bp_seq", 64'(Seq_o), 64'd2);

    // Two strobes mid-frame are dropped; snapshot must not change.
    pulse_done(1'b1);
    set_inputs(32'd77, 100);
    recv("ovr", 16'd2, 32'd50, 0, 1'b0, 3, 7);
    idle_check("ovr");
    chk("ovr_flag", 64'(Overrun_o), 64'd1);
    chk("ovr_drop", 64'(Drop_cnt_o), 64'd2);
    chk("ovr_seq", 64'(Seq_o), 64'd3);
    pulse_clr();
    chk("clr_flag", 64'(Overrun_o), 64'd0);
    chk("clr_drop", 64'(Drop_cnt_o), 64'd0);

    // Back-to-back: strobe on the final-word handshake edge.
    set_inputs(32'd50, 0);
    pulse_done(1'b1);
    set_inputs(32'd77, 100);
    recv("b2b_a", 16'd3, 32'd50, 0, 1'b0, 11, -1);
    recv("b2b_b", 16'd4, 32'd77, 100, 1'b0, -1, -1);
    idle_check("b2b");
    chk("b2b_ovf", 64'(Overrun_o), 64'd0);
    chk("b2b_seq", 64'(Seq_o), 64'd5);

    // Drop coinciding with a clear: the drop wins.
    M_AXIS_tready = 1'b0;
    pulse_done(1'b1);
    pulse_done(1'b1);
    chk("cd_ovf1", 64'(Overrun_o), 64'd1);
    chk("cd_drop1", 64'(Drop_cnt_o), 64'd1);
    pulse_done(1'b1);
    chk("cd_drop2", 64'(Drop_cnt_o), 64'd2);
    @(negedge Clk);
    Done_i = 1'b1;
    Clr_ovf_i = 1'b1;
    @(posedge Clk);
    #1;
    Done_i = 1'b0;
    Clr_ovf_i = 1'b0;
    chk("cd_ovf_win", 64'(Overrun_o), 64'd1);
    chk("cd_drop_win", 64'(Drop_cnt_o), 64'd1);
    recv("cd", 16'd5, 32'd77, 100, 1'b1, -1, -1);
    idle_check("cd");
    pulse_clr();
    chk("cd_clr", 64'(Drop_cnt_o), 64'd0);

    // Enable gating: ignored strobe, then enable dropped mid-frame.
    pulse_done(1'b0);
    @(negedge Clk);
    chk("en_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("en_seq", 64'(Seq_o), 64'd6);
    set_inputs(32'd50, 0);
    pulse_done(1'b1);
    Enable_i = 1'b0;
    recv("en_mid", 16'd6, 32'd50, 0, 1'b0, -1, -1);
    idle_check("en_mid");
    Enable_i = 1'b1;

    // Sequence wrap from 0xFFFF.
    @(negedge Clk);
    force dut.seq_q = 16'hFFFF;
    @(posedge Clk);
    #1;
    release dut.seq_q;
    chk("wrap_pre", 64'(Seq_o), 64'hFFFF);
    pulse_done(1'b1);
    recv("wrap_a", 16'hFFFF, 32'd50, 0, 1'b0, -1, -1);
    chk("wrap_seq0", 64'(Seq_o), 64'd0);
    pulse_done(1'b1);
    recv("wrap_b", 16'h0000, 32'd50, 0, 1'b0, -1, -1);
    idle_check("wrap");

    // Async reset while word 5 is on the bus.
    M_AXIS_tready = 1'b1;
    pulse_done(1'b1);
    repeat (5) @(posedge Clk);
    #2;
    chk("ar_word5", 64'(M_AXIS_tdata), 64'd4);
    Rst_n = 1'b0;
    #1;
    chk("ar_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("ar_tdata", 64'(M_AXIS_tdata), 64'd0);
    chk("ar_tlast", 64'(M_AXIS_tlast), 64'd0);
    chk("ar_busy", 64'(Busy_o), 64'd0);
    chk("ar_seq", 64'(Seq_o), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    pulse_done(1'b1);
    recv("ar_post", 16'd0, 32'd50, 0, 1'b0, -1, -1);
    idle_check("ar_post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
